// File: rtl/packet_disassembler.sv
// packet_disassembler: splits a wide message into MSB-first narrow chunks over val/rdy,
// with a one-entry holding buffer so back-to-back messages stream without bubbles.
module packet_disassembler #(
  parameter int nbits_in  = 32,
  parameter int nbits_out = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_val,
  output logic                 req_rdy,
  input  logic [nbits_in-1:0]  req_msg,
  output logic                 resp_val,
  input  logic                 resp_rdy,
  output logic [nbits_out-1:0] resp_msg
);
  localparam int num_regs = (nbits_in + nbits_out - 1) / nbits_out;
  localparam int sw       = nbits_out * num_regs;
  localparam int cw       = num_regs > 1 ? $clog2(num_regs) : 1;

  logic [sw-1:0]       sr;
  logic                busy;
  logic [cw-1:0]       cnt;
  logic [nbits_in-1:0] hold;
  logic                buf_full;
  logic                resp_fire, last_fire, slot_free, req_fire;

  assign resp_msg  = sr[sw-1 -: nbits_out];
  assign resp_val  = busy;
  assign req_rdy   = !buf_full;
  assign resp_fire = busy & resp_rdy;
  assign last_fire = resp_fire & (cnt == cw'(num_regs - 1));
  assign slot_free = !busy | last_fire;
  assign req_fire  = req_val & !buf_full;

  // Zero-extension on load puts any padding into the top of the first chunk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= '0;
      busy     <= 1'b0;
      cnt      <= '0;
      hold     <= '0;
      buf_full <= 1'b0;
    end else begin
      if (resp_fire) cnt <= last_fire ? '0 : cnt + 1'b1;
      if (slot_free & buf_full) sr <= sw'(hold);
      else if (slot_free & req_fire) sr <= sw'(req_msg);
      else if (resp_fire) sr <= sr << nbits_out;
      if (slot_free) begin
        busy     <= buf_full | req_fire;
        buf_full <= 1'b0;
      end else if (req_fire) begin
        hold     <= req_msg;
        buf_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_packet_disassembler.sv
// tb_packet_disassembler: directed scenarios plus randomized traffic checked against a chunk-queue model.
module tb_packet_disassembler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_val = 0, a_req_rdy, a_resp_val, a_resp_rdy = 0;
  logic [31:0] a_req_msg = 0;
  logic [7:0]  a_resp_msg;
  logic        b_req_val = 0, b_req_rdy, b_resp_val, b_resp_rdy = 0;
  logic [11:0] b_req_msg = 0;
  logic [7:0]  b_resp_msg;
  logic        c_req_val = 0, c_req_rdy, c_resp_val, c_resp_rdy = 0;
  logic [7:0]  c_req_msg = 0;
  logic [7:0]  c_resp_msg;

  packet_disassembler #(.nbits_in(32), .nbits_out(8)) dut_a (.clk(clk), .reset(reset),
    .req_val(a_req_val), .req_rdy(a_req_rdy), .req_msg(a_req_msg),
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_msg(a_resp_msg));
  packet_disassembler #(.nbits_in(12), .nbits_out(8)) dut_b (.clk(clk), .reset(reset),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg));
  packet_disassembler #(.nbits_in(8), .nbits_out(8)) dut_c (.clk(clk), .reset(reset),
    .req_val(c_req_val), .req_rdy(c_req_rdy), .req_msg(c_req_msg),
    .resp_val(c_resp_val), .resp_rdy(c_resp_rdy), .resp_msg(c_resp_msg));

  int vectors = 0;
  int miscompares = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_req_val = 1'b1; a_req_msg = 32'hFFFF_FFFF; a_resp_rdy = 1'b1;
    b_req_val = 1'b1; b_req_msg = 12'hFFF; b_resp_rdy = 1'b1;
    c_req_val = 1'b1; c_req_msg = 8'hFF; c_resp_rdy = 1'b1;
    tick; tick;
    vectors++;
    if ({a_resp_val, a_resp_msg, a_req_rdy} !== {1'b0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_a: val/msg/rdy got %b/%h/%b want 0/00/1", a_resp_val, a_resp_msg, a_req_rdy);
    end
    vectors++;
    if ({b_resp_val, b_resp_msg, b_req_rdy} !== {1'b0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_b: val/msg/rdy got %b/%h/%b want 0/00/1", b_resp_val, b_resp_msg, b_req_rdy);
    end
    vectors++;
    if ({c_resp_val, c_resp_msg, c_req_rdy} !== {1'b0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_c: val/msg/rdy got %b/%h/%b want 0/00/1", c_resp_val, c_resp_msg, c_req_rdy);
    end
    a_req_val = 1'b0; b_req_val = 1'b0; c_req_val = 1'b0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    logic [7:0] e [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    a_resp_rdy = 1'b1;
    a_req_val = 1'b1; a_req_msg = 32'hDEADBEEF;
    tick;
    a_req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_resp_val, a_resp_msg} !== {1'b1, e[i]}) begin
        miscompares++;
        $display("FAIL basic_chunk%0d: got val=%b msg=%h want val=1 msg=%h", i, a_resp_val, a_resp_msg, e[i]);
      end
      tick;
    end
    vectors++;
    if (a_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: got resp_val=%b want 0", a_resp_val);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic rdy_exp;
    a_resp_rdy = 1'b1;
    a_req_val = 1'b1; a_req_msg = 32'h11223344;
    tick;
    for (int c = 1; c <= 8; c++) begin
      rdy_exp = (c == 1 || c >= 5);
      vectors++;
      if ({a_resp_val, a_resp_msg, a_req_rdy} !== {1'b1, e[c-1], rdy_exp}) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: got val=%b msg=%h rdy=%b want 1/%h/%b",
                 c, a_resp_val, a_resp_msg, a_req_rdy, e[c-1], rdy_exp);
      end
      a_req_val = (c == 1);
      a_req_msg = 32'h55667788;
      tick;
    end
    a_req_val = 1'b0;
    vectors++;
    if ({a_resp_val, a_req_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_idle: got val=%b rdy=%b want 0/1", a_resp_val, a_req_rdy);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] e [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    int k = 0;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    a_resp_rdy = 1'b0;
    a_req_val = 1'b1; a_req_msg = 32'hCAFEF00D;
    tick;
    a_req_val = 1'b0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if (stalled) begin
        vectors++;
        if ({a_resp_val, a_resp_msg} !== {1'b1, held}) begin
          miscompares++;
          $display("FAIL bp_hold: got val=%b msg=%h want 1/%h", a_resp_val, a_resp_msg, held);
        end
      end
      a_resp_rdy = c[0];
      if (a_resp_val && a_resp_rdy) begin
        vectors++;
        if (a_resp_msg !== e[k]) begin
          miscompares++;
          $display("FAIL bp_chunk%0d: got %h want %h", k, a_resp_msg, e[k]);
        end
        k++;
      end
      stalled = a_resp_val && !a_resp_rdy;
      held = a_resp_msg;
      tick;
    end
    vectors++;
    if (k !== 4 || a_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_count: got %0d chunks val=%b want 4 chunks val=0", k, a_resp_val);
    end
    a_resp_rdy = 1'b1;
  endtask

  task automatic test_nondivisible;
    logic [15:0] acc = '0;
    b_resp_rdy = 1'b1;
    b_req_val = 1'b1; b_req_msg = 12'hABC;
    tick;
    b_req_val = 1'b0;
    vectors++;
    if ({b_resp_val, b_resp_msg} !== {1'b1, 8'h0A}) begin
      miscompares++;
      $display("FAIL nd_chunk0: got val=%b msg=%h want 1/0a", b_resp_val, b_resp_msg);
    end
    acc[15:8] = b_resp_msg;
    tick;
    vectors++;
    if ({b_resp_val, b_resp_msg} !== {1'b1, 8'hBC}) begin
      miscompares++;
      $display("FAIL nd_chunk1: got val=%b msg=%h want 1/bc", b_resp_val, b_resp_msg);
    end
    acc[7:0] = b_resp_msg;
    tick;
    vectors++;
    if (acc[11:0] !== 12'hABC || b_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL nd_reassembled: got %h val=%b want abc val=0", acc[11:0], b_resp_val);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] e [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    a_resp_rdy = 1'b1;
    a_req_val = 1'b1; a_req_msg = 32'h01020304;
    tick;
    a_req_msg = 32'h05060708;
    tick;
    a_req_val = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++;
    if ({a_resp_val, a_req_rdy} !== 2'b01) begin
      miscompares++;
      $display("FAIL rstmid_state: got val=%b rdy=%b want 0/1", a_resp_val, a_req_rdy);
    end
    tick;
    a_req_val = 1'b1; a_req_msg = 32'hA0B0C0D0;
    tick;
    a_req_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({a_resp_val, a_resp_msg} !== {1'b1, e[i]}) begin
        miscompares++;
        $display("FAIL rstmid_chunk%0d: got val=%b msg=%h want 1/%h", i, a_resp_val, a_resp_msg, e[i]);
      end
      tick;
    end
    vectors++;
    if (a_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got resp_val=%b want 0", a_resp_val);
    end
  endtask

  task automatic test_passthrough;
    c_resp_rdy = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      vectors++;
      if (c_req_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL pt_rdy%0d: got req_rdy=%b want 1", i, c_req_rdy);
      end
      if (i > 0) begin
        vectors++;
        if ({c_resp_val, c_resp_msg} !== {1'b1, 8'(i - 1)}) begin
          miscompares++;
          $display("FAIL pt_chunk%0d: got val=%b msg=%h want 1/%h", i - 1, c_resp_val, c_resp_msg, 8'(i - 1));
        end
      end
      c_req_val = (i < 16);
      c_req_msg = 8'(i);
      tick;
    end
    c_req_val = 1'b0;
  endtask

  // Model: every accepted message contributes its four bytes, MSB first, to an ordered queue.
  task automatic test_random;
    logic [7:0] q[$];
    logic [7:0] want;
    logic stalled = 1'b0;
    logic [7:0] held = '0;
    for (int c = 0; c < 400; c++) begin
      if (stalled) begin
        vectors++;
        if ({a_resp_val, a_resp_msg} !== {1'b1, held}) begin
          miscompares++;
          $display("FAIL rnd_hold%0d: got val=%b msg=%h want 1/%h", c, a_resp_val, a_resp_msg, held);
        end
      end
      a_req_val = ($urandom_range(0, 3) != 0);
      a_req_msg = $urandom;
      a_resp_rdy = ($urandom_range(0, 3) != 0);
      if (a_resp_val && a_resp_rdy) begin
        want = (q.size() > 0) ? q.pop_front() : 8'hxx;
        vectors++;
        if (a_resp_msg !== want) begin
          miscompares++;
          $display("FAIL rnd_chunk%0d: got %h want %h", c, a_resp_msg, want);
        end
      end
      if (a_req_val && a_req_rdy)
        for (int j = 3; j >= 0; j--) q.push_back(a_req_msg[j*8 +: 8]);
      stalled = a_resp_val && !a_resp_rdy;
      held = a_resp_msg;
      tick;
    end
    a_req_val = 1'b0;
    a_resp_rdy = 1'b1;
    for (int c = 0; c < 60 && (q.size() > 0 || a_resp_val); c++) begin
      want = (q.size() > 0) ? q.pop_front() : 8'hxx;
      vectors++;
      if ({a_resp_val, a_resp_msg} !== {1'b1, want}) begin
        miscompares++;
        $display("FAIL rnd_drain: got val=%b msg=%h want 1/%h", a_resp_val, a_resp_msg, want);
      end
      tick;
    end
    vectors++;
    if (q.size() != 0 || a_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_end: got %0d pending, val=%b want 0 pending, val=0", q.size(), a_resp_val);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_backpressure;
    test_nondivisible;
    test_reset_mid;
    test_passthrough;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/packet_disassembler.md
# packet_disassembler

Splits one wide message of `nbits_in` bits into a sequence of narrow chunks of `nbits_out` bits, most-significant chunk first, over a val/rdy stream. It sits directly upstream of the SPI packet assembler. Chaining this block into the assembler, with matching widths, reproduces the original message bit-exactly. A one-entry holding buffer lets the next wide message be accepted while the current one drains, so consecutive messages stream out with no bubbles.

## Interface
- `nbits_in`, default 32: wide input message width. Must satisfy `nbits_in >= nbits_out`.
- `nbits_out`, default 8: narrow output chunk width.
- `num_regs`, derived, not set by users: ceil(`nbits_in`/`nbits_out`), the number of chunks per message.

- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `req_val`  in  1: wide message valid.
- `req_rdy`  out  1: block can accept a wide message.
- `req_msg`  in  `nbits_in`: wide message.
- `resp_val`  out  1: chunk valid.
- `resp_rdy`  in  1: consumer accepts the chunk.
- `resp_msg`  out  `nbits_out`: current chunk.

## Operation
- State:
  - shift register `sr` of width `nbits_out*num_regs`.
  - `busy` flag.
  - chunk counter `cnt`, 0..`num_regs`-1, at least 1 bit wide.
  - holding buffer `buf` of width `nbits_in`, with `buf_full` flag.
- Loading `sr`: the word is zero-extended on the left to `nbits_out*num_regs` bits. Any padding zeros therefore land in the upper bits of the first chunk.
- Output signals:
  - `resp_msg` = top `nbits_out` bits of `sr`.
  - `resp_val` = `busy`.
  - `req_rdy` = !`buf_full`, driven from registers only.
- Fire events:
  - resp fire = `resp_val & resp_rdy`.
  - last fire = resp fire with `cnt == num_regs-1`.
  - slot free = !`busy` OR last fire.
- Non-last resp fire: shift `sr` left by `nbits_out` and increment `cnt`.
- Last fire: set `cnt` to 0. `sr`/`busy` are then updated by the reload rules below.
- Reload priority when slot free, evaluated in the same cycle:
  1. If `buf_full`: `sr` ← ext(`buf`), `busy`=1, `buf_full`=0. `req_rdy` is 0 in this case, so no request can fire.
  2. Otherwise, if req fires: `sr` ← ext(`req_msg`), `busy`=1. The buffer is bypassed.
  3. Otherwise: `busy`=0.
- Req fire while the slot is not free: `buf` ← `req_msg`, `buf_full`=1.
- Order is strictly FIFO. Messages are never dropped or duplicated.
- `num_regs==1`: every resp fire is a last fire, giving one message per cycle at full throughput.

## Timing
- Reset values, applied on the first clock edge with `reset` high:
  - `busy`=0, `buf_full`=0, `cnt`=0, `sr`=0, `buf`=0.
  - Outputs: `resp_val`=0, `resp_msg`=0, `req_rdy`=1.
- During reset, `req_val` and `resp_rdy` are ignored.
- Reset mid-message discards the partial message and any buffered message. No chunk is emitted after reset until a new req fires.
- Latency: a req firing in cycle N with the slot free produces chunk 0 valid in cycle N+1.
- No combinational path from `req_*` to `resp_*`, or from `resp_rdy` to `req_rdy`.
- While `resp_val & !resp_rdy`, `resp_msg` and all state hold stable.
- Throughput: with `resp_rdy` held at 1 and requests always available, `resp_val` stays at 1 continuously. The sustained rate is `num_regs` cycles per message.
- Buffer full: `req_rdy` drops the cycle after the buffer fills. It rises the cycle after the last fire that moves `buf` into `sr`.

## Test plan
- **Basic split.** `nbits_in`=32, `nbits_out`=8, `resp_rdy`=1. Send 0xDEADBEEF in cycle 0. Expect `resp_msg` 0xDE, 0xAD, 0xBE, 0xEF in cycles 1–4, then `resp_val`=0 in cycle 5.
- **Back-to-back with buffering.** Same widths. Offer 0x11223344 in cycle 0 and 0x55667788 in cycle 1; both are accepted. Expect:
  - `req_rdy`=0 in cycles 2–4 and 1 again from cycle 5.
  - chunks 11,22,33,44,55,66,77,88 in cycles 1–8 with no gap.
- **Backpressure.** Send 0xCAFEF00D and toggle `resp_rdy` 0/1 every cycle. Expect:
  - `resp_msg` held stable in every stalled cycle.
  - chunks CA, FE, F0, 0D delivered exactly once, in that order.
- **Non-divisible width.** `nbits_in`=12, `nbits_out`=8. Send 0xABC and expect 0x0A then 0xBC. Then feed the output into the assembler (`nbits_in`=8, `nbits_out`=12) and expect 0xABC out of the assembler.
- **Reset mid-operation.** Assert reset after chunk 1 of 0x01020304, with a second message held in the buffer. Expect:
  - `resp_val`=0 and `req_rdy`=1 after reset.
  - a new message 0xA0B0C0D0 yields only A0, B0, C0, D0.
- **Pass-through.** `nbits_in`=`nbits_out`=8. Stream 0x00..0x0F with `resp_rdy`=1. Expect one chunk per cycle, equal to the input, delayed by 1 cycle, with `req_rdy` held at 1.
